// File: rtl/grid_tracker_pkg.sv
// ============================================================================
// Module  : grid_tracker_pkg
// Purpose : Shared grid geometry defaults and axis-tracker state encoding,
//           used by the grid tracker, display and tile-RAM blocks.
// Contents: DEF_* geometry localparams, trk_state_t (TRK_LOST / TRK_ACTIVE).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package grid_tracker_pkg;

    localparam int DEF_ORIGIN_X = 112;
    localparam int DEF_ORIGIN_Y = 39;
    localparam int DEF_CELL_W   = 32;
    localparam int DEF_CELL_H   = 17;
    localparam int DEF_GRID_W   = 20;
    localparam int DEF_GRID_H   = 20;

    typedef enum logic [0:0] {
        TRK_LOST   = 1'b0,
        TRK_ACTIVE = 1'b1
    } trk_state_t;

endpackage

`default_nettype wire

// File: rtl/grid_axis_tracker.sv
// ============================================================================
// Module  : grid_axis_tracker
// Purpose : One-axis incremental raster tracker. Counts the offset inside a
//           cell and the cell index without any comparator against the
//           absolute position; only consecutive steps are accepted.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           en             - evaluate this cycle (otherwise state holds)
//           start          - origin seen: restart at cell 0, offset 0
//           step / hold    - position is last+1 / equal to last
//           active,idx,sub - tracker state AFTER this cycle's update
//           wrap_last      - offset wraps at its last value (cell crossed)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_axis_tracker
    import grid_tracker_pkg::*;
#(
    parameter int CELL  = 32,
    parameter int CELLS = 20,
    parameter int IDX_W = 5,
    parameter int SUB_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             step,
    input  logic             hold,
    output logic             active,
    output logic [IDX_W-1:0] idx,
    output logic [SUB_W-1:0] sub,
    output logic             wrap_last
);

    localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(CELL - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(CELLS - 1);

    trk_state_t       r_state, w_state;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [SUB_W-1:0] r_sub, w_sub;
    logic             w_cross;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TRK_LOST;
            r_idx   <= '0;
            r_sub   <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_sub   <= w_sub;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_sub   = r_sub;
        w_cross = 1'b0;
        if (en) begin
            if (start) begin
                w_state = TRK_ACTIVE;
                w_idx   = '0;
                w_sub   = '0;
            end else if (r_state == TRK_ACTIVE && !hold) begin
                if (step) begin
                    if (r_sub == C_SUB_LAST) begin
                        w_cross = 1'b1;
                        w_sub   = '0;
                        if (r_idx == C_IDX_LAST) begin
                            // Walked off the far edge of the grid.
                            w_state = TRK_LOST;
                            w_idx   = '0;
                        end else begin
                            w_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_sub = r_sub + 1'b1;
                    end
                end else begin
                    // Discontinuity: cannot know where we are until the origin.
                    w_state = TRK_LOST;
                    w_idx   = '0;
                    w_sub   = '0;
                end
            end
        end
    end

    assign active    = (w_state == TRK_ACTIVE);
    assign idx       = w_idx;
    assign sub       = w_sub;
    assign wrap_last = w_cross;

endmodule

`default_nettype wire

// File: rtl/grid_tracker.sv
// ============================================================================
// Module  : grid_tracker
// Purpose : Pixel-to-grid mapper between VGA timing and the tile RAM. Tracks
//           the raster incrementally and registers grid cell, intra-cell
//           offset, linear RAM address and an in-grid flag, 1-cycle latency.
// Ports   : clk, reset (sync, active high); pos_x, pos_y, pos_valid in;
//           out_valid, in_grid, grid_x, grid_y, sub_x, sub_y, addr out;
//           on_line out (only when GRID_LINES_EN is defined).
// Config  : `define GRID_LINES_EN adds the registered on_line output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_tracker
    import grid_tracker_pkg::*;
#(
    parameter int POS_W    = 11,
    parameter int ORIGIN_X = DEF_ORIGIN_X,
    parameter int ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int CELL_W   = DEF_CELL_W,
    parameter int CELL_H   = DEF_CELL_H,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int IDX_W    = 5,
    parameter int SUB_W    = 5,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    input  logic              pos_valid,
    output logic              out_valid,
    output logic              in_grid,
    output logic [IDX_W-1:0]  grid_x,
    output logic [IDX_W-1:0]  grid_y,
    output logic [SUB_W-1:0]  sub_x,
    output logic [SUB_W-1:0]  sub_y,
    output logic [ADDR_W-1:0] addr
`ifdef GRID_LINES_EN
    ,
    output logic              on_line
`endif
);

    logic [POS_W-1:0]  r_last_x, r_last_y;
    logic [ADDR_W-1:0] r_row_base, w_row_base;
    logic [ADDR_W-1:0] r_lin, w_lin;

    logic w_le, w_x_step, w_x_hold, w_y_step, w_y_hold, w_y_start;
    logic w_x_active, w_y_active, w_x_cross, w_y_cross, w_in;
    logic [IDX_W-1:0] w_x_idx, w_y_idx;
    logic [SUB_W-1:0] w_x_sub, w_y_sub;

    assign w_le      = pos_valid && (pos_x == POS_W'(ORIGIN_X));
    // One extra bit so that all-ones -> 0 is never seen as a step.
    assign w_x_step  = ({1'b0, pos_x} == ({1'b0, r_last_x} + (POS_W+1)'(1)));
    assign w_y_step  = ({1'b0, pos_y} == ({1'b0, r_last_y} + (POS_W+1)'(1)));
    assign w_x_hold  = (pos_x == r_last_x);
    assign w_y_hold  = (pos_y == r_last_y);
    assign w_y_start = (pos_y == POS_W'(ORIGIN_Y));

    grid_axis_tracker #(
        .CELL (CELL_H),
        .CELLS(GRID_H),
        .IDX_W(IDX_W),
        .SUB_W(SUB_W)
    ) u_trk_y (
        .clk      (clk),
        .reset    (reset),
        .en       (w_le),
        .start    (w_y_start),
        .step     (w_y_step),
        .hold     (w_y_hold),
        .active   (w_y_active),
        .idx      (w_y_idx),
        .sub      (w_y_sub),
        .wrap_last(w_y_cross)
    );

    grid_axis_tracker #(
        .CELL (CELL_W),
        .CELLS(GRID_W),
        .IDX_W(IDX_W),
        .SUB_W(SUB_W)
    ) u_trk_x (
        .clk      (clk),
        .reset    (reset),
        .en       (pos_valid),
        .start    (w_le),
        .step     (w_x_step),
        .hold     (w_x_hold),
        .active   (w_x_active),
        .idx      (w_x_idx),
        .sub      (w_x_sub),
        .wrap_last(w_x_cross)
    );

    // row_base follows row*GRID_W; the linear address follows row_base+col.
    // Both are updated by additions only, at the moments row/col change.
    always_comb begin
        w_row_base = r_row_base;
        if (w_le && w_y_start)
            w_row_base = '0;
        else if (w_y_cross)
            w_row_base = r_row_base + ADDR_W'(GRID_W);
    end

    always_comb begin
        w_lin = r_lin;
        if (w_le)
            w_lin = w_row_base;
        else if (w_x_cross)
            w_lin = r_lin + 1'b1;
    end

    assign w_in = w_x_active && w_y_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_row_base <= '0;
            r_lin      <= '0;
            out_valid  <= 1'b0;
            in_grid    <= 1'b0;
            grid_x     <= '0;
            grid_y     <= '0;
            sub_x      <= '0;
            sub_y      <= '0;
            addr       <= '0;
`ifdef GRID_LINES_EN
            on_line    <= 1'b0;
`endif
        end else begin
            out_valid <= pos_valid;
            if (pos_valid) begin
                r_last_x   <= pos_x;
                if (w_le)
                    r_last_y <= pos_y;
                r_row_base <= w_row_base;
                r_lin      <= w_lin;
                in_grid    <= w_in;
                grid_x     <= w_in ? w_x_idx : '0;
                grid_y     <= w_in ? w_y_idx : '0;
                sub_x      <= w_in ? w_x_sub : '0;
                sub_y      <= w_in ? w_y_sub : '0;
                addr       <= w_in ? w_lin   : '0;
`ifdef GRID_LINES_EN
                on_line    <= w_in && (w_x_sub == '0 || w_y_sub == '0);
`endif
            end
        end
    end

endmodule

`default_nettype wire
